// File: rtl/dup_tx_serializer_if.sv
// Device-side bus of the DUP transmit serializer: register/strobe inputs from
// the device, serial line and status outputs back to it.
//   master : the device/register side (drives strobes, data, SEND, bit clock)
//   slave  : the serializer (drives TXD/MDO, ACT, DONE, DLE, TXDBUF read-back)
interface dup_tx_serializer_if;
  logic        devRESET;
  logic        dupINIT;
  logic        txdbufWRITE;
  logic        devLOBYTE;
  logic        devHIBYTE;
  logic [35:0] dupDATAI;
  logic        dupSEND;
  logic        txCLKEN;
  logic        dupTXD;
  logic        dupMDO;
  logic        dupTXACT;
  logic        dupTXDONE;
  logic        dupTXDLE;
  logic [15:0] regTXDBUF;

  modport master (
    output devRESET, dupINIT, txdbufWRITE, devLOBYTE, devHIBYTE, dupDATAI,
           dupSEND, txCLKEN,
    input  dupTXD, dupMDO, dupTXACT, dupTXDONE, dupTXDLE, regTXDBUF
  );

  modport slave (
    input  devRESET, dupINIT, txdbufWRITE, devLOBYTE, devHIBYTE, dupDATAI,
           dupSEND, txCLKEN,
    output dupTXD, dupMDO, dupTXACT, dupTXDONE, dupTXDLE, regTXDBUF
  );
endinterface

// File: rtl/dup_tx_serializer.sv
// DUP byte-oriented transmit serializer: one-byte holding buffer (TXDBUF)
// feeding an 8-bit LSB-first shifter paced by txCLKEN, with data-late fill.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : dup_tx_serializer_if.slave (strobes/data/SEND/txCLKEN in;
//          TXD, MDO, TXACT, TXDONE, TXDLE, regTXDBUF out)
module dup_tx_serializer #(
  parameter logic [7:0] IDLE_FILL = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  dup_tx_serializer_if.slave   bus
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_BIT = '1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sh_data_q, sh_data_d;
  logic                sh_eom_q, sh_eom_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
  logic                buf_som_q, buf_som_d;
  logic                buf_eom_q, buf_eom_d;
  logic                buf_full_q, buf_full_d;
  logic                dle_q, dle_d;
  logic                txd_q, txd_d;
  logic                act_q, act_d;
  logic                done_q, done_d;

  logic                wr_lo;
  logic                abort;
  logic                load;
  logic                fill;

  // Upper data lanes are not used in byte mode.
  logic                unused_data;
  assign unused_data = ^bus.dupDATAI[35:10];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sh_data_q  <= '0;
      sh_eom_q   <= 1'b0;
      bit_cnt_q  <= '0;
      buf_data_q <= '0;
      buf_som_q  <= 1'b0;
      buf_eom_q  <= 1'b0;
      buf_full_q <= 1'b0;
      dle_q      <= 1'b0;
      txd_q      <= 1'b1;
      act_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_data_q  <= sh_data_d;
      sh_eom_q   <= sh_eom_d;
      bit_cnt_q  <= bit_cnt_d;
      buf_data_q <= buf_data_d;
      buf_som_q  <= buf_som_d;
      buf_eom_q  <= buf_eom_d;
      buf_full_q <= buf_full_d;
      dle_q      <= dle_d;
      txd_q      <= txd_d;
      act_q      <= act_d;
      done_q     <= done_d;
    end
  end

  // Next-state, buffer, shifter and output logic.
  always_comb begin
    state_d    = state_q;
    sh_data_d  = sh_data_q;
    sh_eom_d   = sh_eom_q;
    bit_cnt_d  = bit_cnt_q;
    buf_data_d = buf_data_q;
    buf_som_d  = buf_som_q;
    buf_eom_d  = buf_eom_q;
    buf_full_d = buf_full_q;
    dle_d      = dle_q;
    load       = 1'b0;
    fill       = 1'b0;
    wr_lo      = bus.txdbufWRITE & bus.devLOBYTE;
    abort      = bus.dupINIT | bus.devRESET;

    case (state_q)
      IDLE: begin
        if (bus.txCLKEN && bus.dupSEND && buf_full_q) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.txCLKEN) begin
          if (bit_cnt_q != LAST_BIT) begin
            sh_data_d = {1'b0, sh_data_q[DATA_W-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (sh_eom_q || !bus.dupSEND) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else if (buf_full_q) begin
            load = 1'b1;
          end else begin
            fill = 1'b1;
          end
        end
      end
    endcase

    // Shifter load takes the pre-write buffer contents.
    if (load) begin
      sh_data_d  = buf_data_q;
      sh_eom_d   = buf_eom_q;
      bit_cnt_d  = '0;
      buf_full_d = 1'b0;
    end

    if (fill) begin
      sh_data_d = IDLE_FILL;
      sh_eom_d  = 1'b0;
      bit_cnt_d = '0;
    end

    // A write lands after any load, so the buffer ends full.
    if (wr_lo) begin
      buf_data_d = bus.dupDATAI[7:0];
      buf_som_d  = bus.devHIBYTE & bus.dupDATAI[8];
      buf_eom_d  = bus.devHIBYTE & bus.dupDATAI[9];
      buf_full_d = 1'b1;
      dle_d      = 1'b0;
    end

    // Data-late set overrides the write clear.
    if (fill) begin
      dle_d = 1'b1;
    end

    if (abort) begin
      state_d    = IDLE;
      sh_data_d  = '0;
      sh_eom_d   = 1'b0;
      bit_cnt_d  = '0;
      buf_data_d = '0;
      buf_som_d  = 1'b0;
      buf_eom_d  = 1'b0;
      buf_full_d = 1'b0;
      dle_d      = 1'b0;
    end

    txd_d  = (state_d == SHIFT) ? sh_data_d[0] : 1'b1;
    act_d  = (state_d == SHIFT);
    done_d = bus.dupSEND & ~buf_full_q;
  end

  assign bus.dupTXD    = txd_q;
  assign bus.dupMDO    = txd_q;
  assign bus.dupTXACT  = act_q;
  assign bus.dupTXDONE = done_q;
  assign bus.dupTXDLE  = dle_q;
  assign bus.regTXDBUF = {6'b0, buf_eom_q, buf_som_q, buf_data_q};

endmodule
